ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Sequences instruction fetch for the IFU. It owns the architectural PC register and issues one request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. It presents each fetched instruction to the IDU over a valid/ready handshake. It applies branch/jump redirects from the EXU: sequential PC is pc+4, redirect PC is dnpc, and any in-flight or pending fetch on the wrong path is squashed.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
ADDR_W, 32, PC / fetch address width
INST_W, 32, instruction width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
be  input  1  branch/jump redirect strobe from EXU, single-cycle
dnpc_i  input  ADDR_W  redirect target, valid when be=1
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request
imem_req_addr  output  ADDR_W  fetch address
imem_rsp_valid  input  1  fetch response valid, single-cycle pulse
imem_rsp_data  input  INST_W  fetched instruction
inst_valid  output  1  instruction valid to IDU
inst_ready  input  1  IDU accepts instruction
inst_o  output  INST_W  instruction to IDU
pc_o  output  ADDR_W  PC of inst_o

Behaviour:
- Reset (async, rst=1) sets the following, and all take effect immediately, including mid-transaction:
  - state=IDLE, pc=RESET_PC, stale=0
  - imem_req_valid=0, inst_valid=0, inst_o=0, pc_o=RESET_PC
- States: IDLE, REQ, WAIT, HOLD.
- imem_req_valid = (state==REQ). imem_req_addr = pc.
- inst_valid = (state==HOLD && !stale).
- Transitions:
  - IDLE -> REQ unconditionally. The first request is asserted in the 1st cycle after rst deasserts.
  - REQ: hold valid and keep the address stable until imem_req_ready=1. On handshake go to WAIT.
  - WAIT: on imem_rsp_valid:
    - if stale=0, latch inst_o=imem_rsp_data and pc_o=pc, then go to HOLD;
    - if stale=1, drop the data, clear stale, and go to REQ.
  - HOLD: on inst_ready=1, set pc=pc+4 (modulo 2^ADDR_W, wraps silently) and go to REQ.
- Redirect (be=1) is accepted in any state except IDLE. pc is set to dnpc_i the next cycle, and the last redirect wins. Per state:
  - REQ, handshake not occurring this cycle: the request is not yet accepted, so it stays valid with its old address until accepted. stale is set, the response is dropped, and a new REQ is issued at dnpc_i.
  - REQ, handshake occurring the same cycle: stale is set, and the response is dropped.
  - WAIT: stale is set. If imem_rsp_valid occurs the same cycle, that response is dropped and the next state is REQ.
  - HOLD: inst_valid is deasserted the next cycle, the pc+4 update is suppressed, and the next state is REQ. The redirect wins over a simultaneous inst_ready; that instruction counts as consumed by the IDU and no +4 is applied.
  - IDLE: be is ignored.
- Sequential latency: one instruction per (1 REQ + req wait + rsp wait + 1 HOLD) cycles minimum. With zero-wait imem and IDU the period is 3 cycles (REQ, WAIT, HOLD).
- imem_rsp_valid outside WAIT is a protocol error and is ignored.
- inst_o and pc_o hold their value while inst_valid=1 and inst_ready=0.

Optional Feature:
IFU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with dnpc_i[1:0]!=0 does not load pc. Instead the block asserts fetch_misalign sticky, enters IDLE, and stays there until reset. No further requests are issued.
- Undefined: no misalign check is made, dnpc_i[1:0] is forced to 0 when loaded into pc, and the port is absent.

Test Plan:
- Reset release, imem ready=1, rsp 1 cycle after handshake, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008; inst_o/pc_o match each request; period 3 cycles.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1 and imem_req_addr stays 0x80000000 throughout; WAIT is entered only after ready.
- inst_ready=0 for 4 cycles in HOLD with inst_o=0x00000013 -> inst_valid, inst_o and pc_o stable; no new request is issued.
- be=1, dnpc_i=0x80000100 during WAIT -> the pending response is dropped, inst_valid is never asserted for it, and the next request address is 0x80000100.
- be=1 (dnpc_i=0x80000040) in the same cycle as inst_ready=1 in HOLD -> the next request is 0x80000040, not pc+4.
- rst asserted in WAIT -> outputs are reset in the same cycle; after release the first request is at 0x80000000. With IFU_MISALIGN_TRAP_EN defined: dnpc_i=0x80000102 sets fetch_misalign=1 and no further requests are issued.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_fetch_ctrl                                                |
// | Purpose  : IFU fetch sequencer. Owns the architectural PC, issues one    |
// |            instruction-memory request at a time (valid/ready request,    |
// |            valid-only response), hands each instruction to the IDU over  |
// |            valid/ready, and applies EXU branch/jump redirects, squashing |
// |            any wrong-path fetch still in flight.                         |
// | Ports    : clk, rst (async, active-high)                                 |
// |            be, dnpc_i                      - redirect from EXU           |
// |            imem_req_valid/ready/addr       - fetch request channel       |
// |            imem_rsp_valid/data             - fetch response channel      |
// |            inst_valid/ready, inst_o, pc_o  - instruction to IDU          |
// |            fetch_misalign                  - only with the option below  |
// | Options  : IFU_MISALIGN_TRAP_EN - a redirect to a non word-aligned       |
// |            target raises sticky fetch_misalign and parks the fetcher in  |
// |            IDLE until reset. Without it, dnpc_i[1:0] is forced to zero.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ifu_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              be,
  input  logic [ADDR_W-1:0] dnpc_i,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_o,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic              fetch_misalign,
`endif
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] c_PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~(ADDR_W'(3));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  // Address of the request on the bus. Kept apart from r_pc because a
  // redirect during an unaccepted request must not move the bus address.
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_stale;
  logic              r_req_valid;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc_o;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_req_addr_nxt;
  logic              w_stale_nxt;
  logic              w_latch;
  logic              w_misalign;
  logic              w_redirect;
  logic              w_trap;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_inc;

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_trap;
  assign w_misalign     = be && (r_state != S_IDLE) && (dnpc_i[1:0] != 2'b00);
  assign w_redirect_pc  = dnpc_i;
  assign w_trap         = r_trap;
  assign fetch_misalign = r_trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_trap <= 1'b0;
    else     r_trap <= r_trap | w_misalign;
  end
`else
  assign w_misalign    = 1'b0;
  assign w_redirect_pc = dnpc_i & c_ALIGN_MASK;
  assign w_trap        = 1'b0;
`endif

  // be is meaningless in IDLE; a trapping redirect is not a redirect.
  assign w_redirect = be && (r_state != S_IDLE) && !w_misalign;
  assign w_pc_inc   = r_pc + c_PC_STEP;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_stale_nxt    = r_stale;
    w_latch        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_trap) begin
          w_state_nxt    = S_REQ;
          w_req_addr_nxt = r_pc;
        end
      end
      S_REQ: begin
        if (imem_req_ready) w_state_nxt = S_WAIT;
        // The outstanding (or just accepted) request is now wrong-path:
        // let it complete on the bus and drop its response.
        if (w_redirect) begin
          w_stale_nxt = 1'b1;
          w_pc_nxt    = w_redirect_pc;
        end
      end
      S_WAIT: begin
        if (w_redirect) w_pc_nxt = w_redirect_pc;
        if (imem_rsp_valid) begin
          if (r_stale || w_redirect) begin
            // Response consumed and discarded; nothing remains in flight.
            w_state_nxt    = S_REQ;
            w_stale_nxt    = 1'b0;
            w_req_addr_nxt = w_redirect ? w_redirect_pc : r_pc;
          end else begin
            w_state_nxt = S_HOLD;
            w_latch     = 1'b1;
          end
        end else if (w_redirect) begin
          w_stale_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect beats inst_ready: the held instruction is treated as
        // consumed but the sequential +4 is not applied.
        if (w_redirect) begin
          w_state_nxt    = S_REQ;
          w_pc_nxt       = w_redirect_pc;
          w_req_addr_nxt = w_redirect_pc;
        end else if (inst_ready) begin
          w_state_nxt    = S_REQ;
          w_pc_nxt       = w_pc_inc;
          w_req_addr_nxt = w_pc_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_misalign) begin
      w_state_nxt = S_IDLE;
      w_pc_nxt    = r_pc;
      w_stale_nxt = 1'b0;
      w_latch     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_stale      <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_pc_o       <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_stale      <= w_stale_nxt;
      r_req_valid  <= (w_state_nxt == S_REQ);
      r_inst_valid <= (w_state_nxt == S_HOLD) && !w_stale_nxt;
      if (w_latch) begin
        r_inst <= imem_rsp_data;
        r_pc_o <= r_pc;
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign inst_valid     = r_inst_valid;
  assign inst_o         = r_inst;
  assign pc_o           = r_pc_o;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifu_fetch_ctrl                                             |
// | Purpose  : Directed self-checking bench for ifu_fetch_ctrl. A small      |
// |            instruction-memory model inside tick() answers each accepted  |
// |            request one cycle later with mem_word(addr).                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] c_RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        be = 1'b0;
  logic [31:0] dnpc_i = '0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_ready = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  bit auto_rsp = 1'b1;
  bit use_nop  = 1'b0;
  int checks   = 0;
  int failures = 0;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .be             (be),
    .dnpc_i         (dnpc_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
`ifdef IFU_MISALIGN_TRAP_EN
    .fetch_misalign (fetch_misalign),
`endif
    .pc_o           (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  // One clock. Inputs change and outputs are sampled 1 time unit after the
  // rising edge. An accepted request is answered for exactly one cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    @(posedge clk);
    #1;
    imem_rsp_valid = hs && auto_rsp;
    imem_rsp_data  = use_nop ? 32'h0000_0013 : mem_word(a);
  endtask

  // Leaves the DUT in its first REQ cycle at c_RST_PC.
  task automatic do_reset();
    rst = 1'b1; be = 1'b0; imem_rsp_valid = 1'b0; auto_rsp = 1'b1; use_nop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_o !== 32'h0) begin failures++; $display("FAIL rst_inst_o got=%h exp=0", inst_o); end
    checks++; if (pc_o !== c_RST_PC) begin failures++; $display("FAIL rst_pc_o got=%h exp=%h", pc_o, c_RST_PC); end
    checks++; if (imem_req_addr !== c_RST_PC) begin failures++; $display("FAIL rst_req_addr got=%h exp=%h", imem_req_addr, c_RST_PC); end
`ifdef IFU_MISALIGN_TRAP_EN
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", fetch_misalign); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== c_RST_PC) begin failures++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, c_RST_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = c_RST_PC + 32'(4 * i);
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin failures++; $display("FAIL seq_req%0d got=%b/%h exp=1/%h", i, imem_req_valid, imem_req_addr, e); end
      tick();
      checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got=%b/%b exp=0/0", i, imem_req_valid, inst_valid); end
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_o !== mem_word(e) || pc_o !== e) begin failures++; $display("FAIL seq_hold%0d got=%b/%h/%h exp=1/%h/%h", i, inst_valid, inst_o, pc_o, mem_word(e), e); end
      tick();
    end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C) begin failures++; $display("FAIL seq_req3 got=%b/%h exp=1/8000000c", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_req_stall();
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== c_RST_PC) begin failures++; $display("FAIL stall_req%0d got=%b/%h exp=1/%h", i, imem_req_valid, imem_req_addr, c_RST_PC); end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_wait got=%b exp=0", imem_req_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_o !== mem_word(c_RST_PC)) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/%h", inst_valid, inst_o, mem_word(c_RST_PC)); end
    tick();
  endtask

  task automatic test_hold_stall();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    do_reset();
    use_nop = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst_o !== 32'h13 || pc_o !== c_RST_PC || imem_req_valid !== 1'b0)
        begin failures++; $display("FAIL hold%0d got=%b/%h/%h/%b exp=1/00000013/%h/0", i, inst_valid, inst_o, pc_o, imem_req_valid, c_RST_PC); end
      if (i == 1) begin imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; end
      tick();
    end
    inst_ready = 1'b1; use_nop = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin failures++; $display("FAIL hold_next got=%b/%h exp=1/80000004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    tick();
    be = 1'b1; dnpc_i = 32'h8000_0100;
    tick();
    be = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin failures++; $display("FAIL rwait_req got=%b/%b/%h exp=0/1/80000100", inst_valid, imem_req_valid, imem_req_addr); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rwait_noinst got=%b exp=0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_o !== mem_word(32'h8000_0100) || pc_o !== 32'h8000_0100) begin failures++; $display("FAIL rwait_hold got=%b/%h/%h exp=1/%h/80000100", inst_valid, inst_o, pc_o, mem_word(32'h8000_0100)); end
    tick();
    auto_rsp = 1'b0;
    tick();
    be = 1'b1; dnpc_i = 32'h8000_0180;
    tick();
    be = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rwait_stale got=%b/%b exp=0/0", imem_req_valid, inst_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    tick();
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0180) begin failures++; $display("FAIL rwait_drop got=%b/%b/%h exp=0/1/80000180", inst_valid, imem_req_valid, imem_req_addr); end
    auto_rsp = 1'b1;
  endtask

  task automatic test_redirect_hold();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    do_reset();
    tick(); tick();
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL rhold_valid got=%b exp=1", inst_valid); end
    be = 1'b1; dnpc_i = 32'h8000_0040; inst_ready = 1'b1;
    tick();
    be = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0040 || inst_valid !== 1'b0) begin failures++; $display("FAIL rhold_req got=%b/%h/%b exp=1/80000040/0", imem_req_valid, imem_req_addr, inst_valid); end
    tick(); tick();
    checks++; if (inst_valid !== 1'b1 || pc_o !== 32'h8000_0040) begin failures++; $display("FAIL rhold_pc got=%b/%h exp=1/80000040", inst_valid, pc_o); end
    tick();
  endtask

  task automatic test_redirect_req();
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    do_reset();
    be = 1'b1; dnpc_i = 32'h8000_0200;
    tick();
    be = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== c_RST_PC) begin failures++; $display("FAIL rreq_hold got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, c_RST_PC); end
    imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rreq_wait got=%b exp=0", imem_req_valid); end
    tick();
    checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin failures++; $display("FAIL rreq_new got=%b/%b/%h exp=0/1/80000200", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    do_reset();
    tick(); tick();
    be = 1'b1; dnpc_i = 32'hFFFF_FFFC; inst_ready = 1'b1;
    tick();
    be = 1'b0;
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_req_addr); end
    tick(); tick();
    checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc_o); end
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_misalign();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    do_reset();
    tick(); tick();
    be = 1'b1; dnpc_i = 32'h8000_0102;
    tick();
    be = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    checks++; if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL mis_trap got=%b/%b/%b exp=1/0/0", fetch_misalign, imem_req_valid, inst_valid); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL mis_park got=%b/%b exp=1/0", fetch_misalign, imem_req_valid); end
`else
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin failures++; $display("FAIL mis_align got=%b/%h exp=1/80000100", imem_req_valid, imem_req_addr); end
`endif
  endtask

  task automatic test_reset_in_wait();
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    tick(); tick(); tick(); tick();
    checks++; if (imem_req_addr !== 32'h8000_0004 || inst_o !== mem_word(c_RST_PC)) begin failures++; $display("FAIL arst_pre got=%h/%h exp=80000004/%h", imem_req_addr, inst_o, mem_word(c_RST_PC)); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_o !== 32'h0 || pc_o !== c_RST_PC || imem_req_addr !== c_RST_PC)
      begin failures++; $display("FAIL arst_now got=%b/%b/%h/%h/%h exp=0/0/00000000/%h/%h", imem_req_valid, inst_valid, inst_o, pc_o, imem_req_addr, c_RST_PC, c_RST_PC); end
`ifdef IFU_MISALIGN_TRAP_EN
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL arst_misalign got=%b exp=0", fetch_misalign); end
`endif
    tick();
    rst = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== c_RST_PC) begin failures++; $display("FAIL arst_first got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, c_RST_PC); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_req_stall();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_req();
    test_wrap();
    test_misalign();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
